// File: rtl/bus_pkg.sv
// Shared definitions for the serial-bus arbiter, masters and slaves:
// arbiter state encoding and the default grant-wait watchdog width.
package bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_GNT_WAIT = 2'd1,
        ARB_BUSY     = 2'd2,
        ARB_REL      = 2'd3
    } arb_state_t;

    // Default watchdog width; the limit is 2^TIMEOUT_LEN-1 clocks.
    localparam int TIMEOUT_LEN_DEF = 6;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first set req bit searching
// upward from last+1 with wrap-around, so the previous owner ranks lowest.
module rr_picker #(
    parameter int N_MASTERS = 4,
    parameter int ID_W      = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [ID_W-1:0]      last,
    output logic                 valid,
    output logic [ID_W-1:0]      idx
);

    // Rotating search; the first hit freezes idx, later hits are ignored.
    always_comb begin : p_pick
        int j;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            j     = (int'(last) + i) % N_MASTERS;
            idx   = (req[j] && !valid) ? ID_W'(j) : idx;
            valid = valid | req[j];
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared serial bus; grant held while the owner drives bus_util.
// Optional grant-wait watchdog enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_MASTERS   = 4,
    parameter int ID_W        = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
    parameter int TIMEOUT_LEN = TIMEOUT_LEN_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_MASTERS-1:0] req,
    input  logic                 bus_util,
    input  logic                 slv_bsy,
    output logic [N_MASTERS-1:0] grant,
    output logic [ID_W-1:0]      grant_id,
    output logic                 arb_busy,
    output logic                 timeout_err
);

    localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_MASTERS - 1);

    arb_state_t      state_r;
    logic [ID_W-1:0] last_r;
    logic            pick_valid_s;
    logic [ID_W-1:0] pick_idx_s;
    logic            owner_req_s;
    logic            to_hit_s;

    function automatic logic [N_MASTERS-1:0] to_onehot(input logic [ID_W-1:0] i);
        logic [N_MASTERS-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    rr_picker #(
        .N_MASTERS (N_MASTERS),
        .ID_W      (ID_W)
    ) u_picker (
        .req   (req),
        .last  (last_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    assign owner_req_s = req[grant_id];

`ifdef ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_LEN-1:0] TO_ONE  = TIMEOUT_LEN'(1);
    // Value one below all-ones: the increment that would reach all-ones revokes.
    localparam logic [TIMEOUT_LEN-1:0] TO_LAST = ~TO_ONE;

    logic [TIMEOUT_LEN-1:0] to_cnt_r;

    // Watchdog counts cycles spent in GNT_WAIT and sits at zero elsewhere.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt_r <= '0;
        end else if (state_r == ARB_GNT_WAIT) begin
            to_cnt_r <= to_cnt_r + TO_ONE;
        end else begin
            to_cnt_r <= '0;
        end
    end

    assign to_hit_s = (state_r == ARB_GNT_WAIT) && (to_cnt_r == TO_LAST);
`else
    assign to_hit_s = 1'b0;
`endif

    // Arbiter FSM with registered grant, grant_id, arb_busy and timeout_err.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ARB_IDLE;
            grant       <= '0;
            grant_id    <= '0;
            arb_busy    <= 1'b0;
            timeout_err <= 1'b0;
            last_r      <= LAST_RST;
        end else begin
            timeout_err <= 1'b0;
            case (state_r)
                ARB_IDLE: begin
                    // A foreign or stuck bus_util driver blocks new grants.
                    if (pick_valid_s && !slv_bsy && !bus_util) begin
                        grant    <= to_onehot(pick_idx_s);
                        grant_id <= pick_idx_s;
                        arb_busy <= 1'b1;
                        state_r  <= ARB_GNT_WAIT;
                    end else begin
                        grant    <= '0;
                        arb_busy <= 1'b0;
                        state_r  <= ARB_IDLE;
                    end
                end
                ARB_GNT_WAIT: begin
                    if (bus_util) begin
                        state_r <= ARB_BUSY;
                    end else if (!owner_req_s) begin
                        grant   <= '0;
                        state_r <= ARB_REL;
                    end else if (to_hit_s) begin
                        grant       <= '0;
                        timeout_err <= 1'b1;
                        state_r     <= ARB_REL;
                    end else begin
                        state_r <= ARB_GNT_WAIT;
                    end
                end
                ARB_BUSY: begin
                    if (!bus_util) begin
                        grant   <= '0;
                        state_r <= ARB_REL;
                    end else begin
                        state_r <= ARB_BUSY;
                    end
                end
                ARB_REL: begin
                    // Owner (or watchdog offender) drops to lowest priority.
                    last_r   <= grant_id;
                    grant    <= '0;
                    arb_busy <= 1'b0;
                    state_r  <= ARB_IDLE;
                end
                default: begin
                    grant    <= '0;
                    arb_busy <= 1'b0;
                    state_r  <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scoreboard bench for bus_arbiter (4 masters); the watchdog steps
// take the ARB_TIMEOUT_EN or plain branch to match the build.
module tb_bus_arbiter;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    logic       clk;
    logic       rstn;
    logic [3:0] req;
    logic       bus_util;
    logic       slv_bsy;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       arb_busy;
    logic       timeout_err;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    bus_arbiter #(
        .N_MASTERS   (4),
        .ID_W        (2),
        .TIMEOUT_LEN (6)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req         (req),
        .bus_util    (bus_util),
        .slv_bsy     (slv_bsy),
        .grant       (grant),
        .grant_id    (grant_id),
        .arb_busy    (arb_busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input string tag, input logic [3:0] g, input logic [1:0] id,
                            input logic busy, input logic terr);
        exp_t e;
        e.tag = tag;
        e.val = {terr, busy, id, g};
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t       e;
        logic [7:0] obs;
        obs = {timeout_err, arb_busy, grant_id, grant};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty: observed %02h required an entry", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                n_bad++;
                $error("FAIL %s: observed {terr,busy,id,grant}=%02h required %02h", e.tag, obs, e.val);
            end
        end
    endtask

    // Inputs are already driven; expect the outputs after the next edge.
    task automatic step(input string tag, input logic [3:0] g, input logic [1:0] id,
                        input logic busy, input logic terr);
        push_exp(tag, g, id, busy, terr);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rstn     = 1'b0;
        req      = 4'b0000;
        bus_util = 1'b0;
        slv_bsy  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push_exp("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        check_out();
        rstn = 1'b1;

        // T3: all masters requesting, order 0,1,2,3 with REL gaps
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            bus_util = 1'b0;
            step("t3_gnt",  4'b0001 << k, 2'(k), 1'b1, 1'b0);
            bus_util = 1'b1;
            step("t3_busy", 4'b0001 << k, 2'(k), 1'b1, 1'b0);
            step("t3_hold", 4'b0001 << k, 2'(k), 1'b1, 1'b0);
            bus_util = 1'b0;
            step("t3_rel",  4'b0000,      2'(k), 1'b1, 1'b0);
            if (k == 3) req = 4'b0000;
            step("t3_idle", 4'b0000,      2'(k), 1'b0, 1'b0);
        end

        // T2: single master, 20-clock transfer
        req = 4'b0100;
        step("t2_gnt", 4'b0100, 2'd2, 1'b1, 1'b0);
        bus_util = 1'b1;
        req      = 4'b0000;
        repeat (20) step("t2_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
        bus_util = 1'b0;
        step("t2_rel",  4'b0000, 2'd2, 1'b1, 1'b0);
        step("t2_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

        // T4: slave busy blocks the grant
        slv_bsy = 1'b1;
        req     = 4'b0010;
        repeat (3) step("t4_blocked", 4'b0000, 2'd2, 1'b0, 1'b0);
        slv_bsy = 1'b0;
        step("t4_gnt", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        step("t4_wd",   4'b0000, 2'd1, 1'b1, 1'b0);
        step("t4_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

        // T5: owner withdraws before bus_util; pending master 0 served next
        req = 4'b1001;
        step("t5_gnt", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0001;
        step("t5_rel",  4'b0000, 2'd3, 1'b1, 1'b0);
        step("t5_idle", 4'b0000, 2'd3, 1'b0, 1'b0);
        step("t5_next", 4'b0001, 2'd0, 1'b1, 1'b0);
        bus_util = 1'b1;
        step("t5_busy", 4'b0001, 2'd0, 1'b1, 1'b0);

        // T1: asynchronous reset in the middle of BUSY
        #2;
        rstn = 1'b0;
        #1;
        push_exp("t1_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        check_out();
        @(posedge clk);
        #1;
        bus_util = 1'b0;
        req      = 4'b0001;
        rstn     = 1'b1;
        step("t1_gnt", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        step("t1_rel",  4'b0000, 2'd0, 1'b1, 1'b0);
        step("t1_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // bus_util already high in IDLE: no grant until it drops
        bus_util = 1'b1;
        req      = 4'b0010;
        repeat (2) step("stuck_util", 4'b0000, 2'd0, 1'b0, 1'b0);
        bus_util = 1'b0;
        step("stuck_gnt", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        step("stuck_rel",  4'b0000, 2'd1, 1'b1, 1'b0);
        step("stuck_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

        // T6: owner never raises bus_util
        req = 4'b0101;
        step("t6_gnt", 4'b0100, 2'd2, 1'b1, 1'b0);
        repeat (62) step("t6_wait", 4'b0100, 2'd2, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
        step("t6_revoke", 4'b0000, 2'd2, 1'b1, 1'b1);
        step("t6_idle",   4'b0000, 2'd2, 1'b0, 1'b0);
        step("t6_next",   4'b0001, 2'd0, 1'b1, 1'b0);
`else
        repeat (4) step("t6_no_wdog", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0000;
        step("t6_rel",  4'b0000, 2'd2, 1'b1, 1'b0);
        step("t6_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
